jpeg_huffman_decoder: RTL



---
 rtl/jpeg_huffman_decoder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/jpeg_huffman_decoder.sv
// Canonical JPEG Huffman decoder: builds MINCODE/MAXCODE/VALPTR, then decodes one bit per cycle.
// Optional invalid-code error state enabled by defining HUFF_DEC_ERR_EN.
module jpeg_huffman_decoder #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned NVAL    = 162
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] huff_count_in [0:MAX_LEN-1],
  input  logic [7:0] huff_val_in   [0:NVAL-1],
  output logic       tbl_ready,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [7:0] sym_out,
  output logic [4:0] sym_len,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       err
);

`ifdef HUFF_DEC_ERR_EN
  typedef enum logic [2:0] {StIdle, StBuild, StDecode, StHold, StErr} state_t;
`else
  typedef enum logic [2:0] {StIdle, StBuild, StDecode, StHold} state_t;
`endif

  state_t r_state, w_state_d;

  // Build-phase running state
  logic [3:0]  r_l;
  logic [16:0] r_code;
  logic [7:0]  r_k;

  // Derived tables, entry i describes code length i+1
  logic [16:0] r_mincode [0:MAX_LEN-1];
  logic [16:0] r_maxcode [0:MAX_LEN-1];
  logic [7:0]  r_valptr  [0:MAX_LEN-1];
  logic [MAX_LEN-1:0] r_empty;

  // Decode-phase state; acc never needs to hold more than 15 bits between cycles
  logic [14:0] r_acc;
  logic [3:0]  r_n;
  logic [7:0]  r_sym;
  logic [4:0]  r_len;
  logic        r_sym_valid;

  logic [7:0]  w_cnt;
  logic [15:0] w_acc_nx;
  logic [3:0]  w_ni;
  logic        w_match;
  logic        w_last;
  logic [7:0]  w_idx;
  logic [7:0]  w_sym;

  assign w_cnt    = huff_count_in[r_l];
  assign w_acc_nx = {r_acc, bit_in};
  assign w_ni     = r_n;
  assign w_last   = (r_n == 4'd15);
  assign w_match  = !r_empty[w_ni] && ({1'b0, w_acc_nx} <= r_maxcode[w_ni]);
  assign w_idx    = 8'({9'd0, r_valptr[w_ni]} + {1'b0, w_acc_nx} - r_mincode[w_ni]);
  assign w_sym    = (32'(w_idx) < NVAL) ? huff_val_in[w_idx] : 8'd0;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   w_state_d = StIdle;
      StBuild:  if (r_l == 4'd15) w_state_d = StDecode;
      StDecode: begin
        if (bit_valid) begin
          if (w_match) w_state_d = StHold;
`ifdef HUFF_DEC_ERR_EN
          else if (w_last) w_state_d = StErr;
`endif
        end
      end
      StHold:   if (sym_ready) w_state_d = StDecode;
`ifdef HUFF_DEC_ERR_EN
      StErr:    w_state_d = StErr;
`endif
      default:  w_state_d = StIdle;
    endcase
    if (load) w_state_d = StBuild;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && !load && r_state == StBuild) begin
      r_mincode[r_l] <= r_code;
      r_valptr[r_l]  <= r_k;
      r_empty[r_l]   <= (w_cnt == 8'd0);
      r_maxcode[r_l] <= r_code + {9'd0, w_cnt} - 17'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || load) begin
      r_l         <= 4'd0;
      r_code      <= 17'd0;
      r_k         <= 8'd0;
      r_acc       <= 15'd0;
      r_n         <= 4'd0;
      r_sym_valid <= 1'b0;
      if (rst) begin
        r_sym <= 8'd0;
        r_len <= 5'd0;
      end
    end else begin
      unique case (r_state)
        StBuild: begin
          r_code <= (r_code + {9'd0, w_cnt}) << 1;
          r_k    <= r_k + w_cnt;
          r_l    <= r_l + 4'd1;
        end
        StDecode: begin
          if (bit_valid) begin
            if (w_match) begin
              r_sym       <= w_sym;
              r_len       <= {1'b0, r_n} + 5'd1;
              r_sym_valid <= 1'b1;
              r_acc       <= 15'd0;
              r_n         <= 4'd0;
            end else if (w_last) begin
              r_acc <= 15'd0;
              r_n   <= 4'd0;
            end else begin
              r_acc <= w_acc_nx[14:0];
              r_n   <= r_n + 4'd1;
            end
          end
        end
        StHold: if (sym_ready) r_sym_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef HUFF_DEC_ERR_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (rst || load) r_err <= 1'b0;
    else if (r_state == StDecode && bit_valid && !w_match && w_last) r_err <= 1'b1;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign tbl_ready = (r_state == StDecode) || (r_state == StHold);
  assign bit_ready = (r_state == StDecode);
  assign sym_out   = r_sym;
  assign sym_len   = r_len;
  assign sym_valid = r_sym_valid;

endmodule
